// File: rtl/loader_defs.sv
// Shared definitions for the serial program loader.
// State encoding, default frame marker and small helpers.
package loader_defs;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    ADDR_LO = 3'd1,
    ADDR_HI = 3'd2,
    LEN_LO  = 3'd3,
    LEN_HI  = 3'd4,
    DATA    = 3'd5,
    CSUM    = 3'd6,
    DONE    = 3'd7
  } state_e;

  function automatic logic is_timed(input state_e s);
    return (s != SYNC) && (s != DONE);
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle-cycle watchdog between bytes of a frame.
// Counts while enabled, saturates at TIMEOUT.
module idle_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: parses framed images into memory
// and holds the CPU in reset until a frame loads cleanly.
module program_loader
  import loader_defs::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         TIMEOUT   = 1024
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        InValid,
  input  logic [7:0]  InData,
  output logic        InReady,
  output logic        WE,
  output logic [15:0] Address,
  output logic [7:0]  DataOut,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  state_e state_q, state_d;

  logic [15:0] wptr_q, wptr_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        rdy_q, rdy_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        loaded_q, loaded_d;

  logic accept;
  logic expired;

  assign accept = InValid && rdy_q;

  idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clear  (accept),
    .enable (is_timed(state_q)),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    len_d    = len_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    dout_d   = dout_q;
    err_d    = err_q;
    loaded_d = loaded_q;

    unique case (state_q)
      SYNC: begin
        if (accept && InData == SYNC_BYTE) begin
          state_d = ADDR_LO;
          csum_d  = 8'h00;
          err_d   = 1'b0;
        end
      end
      ADDR_LO: begin
        if (accept) begin
          wptr_d[7:0] = InData;
          state_d     = ADDR_HI;
        end
      end
      ADDR_HI: begin
        if (accept) begin
          wptr_d[15:8] = InData;
          state_d      = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = InData;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = InData;
          if ({InData, len_q[7:0]} == 16'h0000) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          we_d   = 1'b1;
          addr_d = wptr_q;
          dout_d = InData;
          wptr_d = wptr_q + 16'd1;
          len_d  = len_q - 16'd1;
          csum_d = csum_q + InData;
          if (len_q == 16'd1) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          if (InData == csum_q) begin
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = SYNC;
          end
        end
      end
      DONE: begin
        state_d = SYNC;
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    // An accepted byte on the expiry edge keeps the frame alive.
    if (expired && !accept) begin
      state_d = SYNC;
      err_d   = 1'b1;
    end

    if (state_d == DONE) begin
      loaded_d = 1'b1;
    end
    rdy_d  = (state_d != DONE);
    done_d = (state_d == DONE);
    hold_d = (state_d != SYNC) || !loaded_d;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= SYNC;
      wptr_q   <= '0;
      len_q    <= '0;
      csum_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      rdy_q    <= 1'b1;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      len_q    <= len_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rdy_q    <= rdy_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
    end
  end

  assign InReady = rdy_q;
  assign WE      = we_q;
  assign Address = addr_q;
  assign DataOut = dout_q;
  assign CpuHold = hold_q;
  assign Done    = done_q;
  assign Error   = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes queued
// when frames are built, compared as the DUT writes memory.
module tb_program_loader;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        InValid = 1'b0;
  logic [7:0]  InData = 8'h00;
  logic        InReady;
  logic        WE;
  logic [15:0] Address;
  logic [7:0]  DataOut;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [23:0] exp_q[$];
  int          wr_cyc[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  dq[$];

  program_loader #(
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TO)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .InValid(InValid),
    .InData (InData),
    .InReady(InReady),
    .WE     (WE),
    .Address(Address),
    .DataOut(DataOut),
    .CpuHold(CpuHold),
    .Done   (Done),
    .Error  (Error)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    logic [23:0] e;
    if (Done === 1'b1) done_cnt++;
    if (WE === 1'b1) begin
      wr_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", Address, DataOut);
      end else begin
        e = exp_q.pop_front();
        if ({Address, DataOut} !== e) begin
          errors++;
          $display("FAIL write got=%h/%h want=%h/%h",
                   Address, DataOut, e[23:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge CLK);
    while (InReady !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=%b want=1", InReady);
    end
    InValid = 1'b1;
    InData  = b;
    @(posedge CLK);
  endtask

  task automatic flush();
    while (tx_q.size() > 0) send(tx_q.pop_front());
  endtask

  task automatic idle();
    @(negedge CLK);
    InValid = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic build(input logic [15:0] a, input logic [7:0] cs,
                       input bit expw);
    logic [15:0] n;
    logic [15:0] ai;
    n = 16'(dq.size());
    tx_q.push_back(8'hA5);
    tx_q.push_back(a[7:0]);
    tx_q.push_back(a[15:8]);
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    for (int i = 0; i < dq.size(); i++) begin
      tx_q.push_back(dq[i]);
      ai = a + 16'(i);
      if (expw) exp_q.push_back({ai, dq[i]});
    end
    tx_q.push_back(cs);
    dq.delete();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    checks += 7;
    if (WE !== 1'b0) begin errors++; $display("FAIL rst_we got=%b want=0", WE); end
    if (Address !== 16'h0) begin errors++; $display("FAIL rst_addr got=%h want=0", Address); end
    if (DataOut !== 8'h0) begin errors++; $display("FAIL rst_dout got=%h want=0", DataOut); end
    if (Done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", Done); end
    if (Error !== 1'b0) begin errors++; $display("FAIL rst_err got=%b want=0", Error); end
    if (CpuHold !== 1'b1) begin errors++; $display("FAIL rst_hold got=%b want=1", CpuHold); end
    if (InReady !== 1'b1) begin errors++; $display("FAIL rst_rdy got=%b want=1", InReady); end
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks += 2;
    if (CpuHold !== 1'b1) begin errors++; $display("FAIL post_rst_hold got=%b want=1", CpuHold); end
    if (InReady !== 1'b1) begin errors++; $display("FAIL post_rst_rdy got=%b want=1", InReady); end
  endtask

  task automatic test_bad_csum();
    int d0 = done_cnt;
    dq = '{8'h11, 8'h22, 8'h33};
    build(16'h0300, 8'h67, 1'b1);
    flush();
    idle();
    checks += 4;
    if (exp_q.size() != 0) begin errors++; $display("FAIL bad_writes left=%0d want=0", exp_q.size()); end
    if (Error !== 1'b1) begin errors++; $display("FAIL bad_err got=%b want=1", Error); end
    if (done_cnt != d0) begin errors++; $display("FAIL bad_done got=%0d want=%0d", done_cnt, d0); end
    if (CpuHold !== 1'b1) begin errors++; $display("FAIL bad_hold got=%b want=1", CpuHold); end
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    wr_cyc.delete();
    dq = '{8'h11, 8'h22, 8'h33};
    build(16'h0300, 8'h66, 1'b1);
    flush();
    idle();
    checks += 5;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_writes left=%0d want=0", exp_q.size()); end
    if (wr_cyc.size() != 3) begin
      errors++;
      $display("FAIL basic_nwr got=%0d want=3", wr_cyc.size());
    end else begin
      checks++;
      if (wr_cyc[1] != wr_cyc[0] + 1 || wr_cyc[2] != wr_cyc[1] + 1) begin
        errors++;
        $display("FAIL basic_consec got=%0d,%0d,%0d want=consecutive",
                 wr_cyc[0], wr_cyc[1], wr_cyc[2]);
      end
    end
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL basic_done got=%0d want=%0d", done_cnt, d0 + 1); end
    if (CpuHold !== 1'b0) begin errors++; $display("FAIL basic_hold got=%b want=0", CpuHold); end
    if (Error !== 1'b0) begin errors++; $display("FAIL basic_err got=%b want=0", Error); end
  endtask

  task automatic test_wrap();
    int d0 = done_cnt;
    dq = '{8'hAA, 8'hBB};
    build(16'hFFFF, 8'h65, 1'b1);
    flush();
    idle();
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_writes left=%0d want=0", exp_q.size()); end
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL wrap_done got=%0d want=%0d", done_cnt, d0 + 1); end
    if (Error !== 1'b0) begin errors++; $display("FAIL wrap_err got=%b want=0", Error); end
  endtask

  task automatic test_garbage();
    int d0 = done_cnt;
    tx_q = '{8'h00, 8'hFF, 8'h12};
    dq = '{8'h01, 8'h02, 8'h03};
    build(16'h1000, 8'h06, 1'b1);
    flush();
    idle();
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL garb_writes left=%0d want=0", exp_q.size()); end
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL garb_done got=%0d want=%0d", done_cnt, d0 + 1); end
    if (Error !== 1'b0) begin errors++; $display("FAIL garb_err got=%b want=0", Error); end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    int n = 0;
    tx_q = '{8'hA5, 8'h00, 8'h03, 8'h03};
    flush();
    @(negedge CLK);
    InValid = 1'b0;
    while (Error !== 1'b1 && n < 4 * TO) begin
      @(negedge CLK);
      n++;
    end
    checks += 4;
    if (Error !== 1'b1) begin errors++; $display("FAIL to_err got=%b want=1", Error); end
    if (CpuHold !== 1'b0) begin errors++; $display("FAIL to_sync_hold got=%b want=0", CpuHold); end
    if (InReady !== 1'b1) begin errors++; $display("FAIL to_rdy got=%b want=1", InReady); end
    if (done_cnt != d0) begin errors++; $display("FAIL to_done got=%0d want=%0d", done_cnt, d0); end
    dq = '{8'h05, 8'h06};
    build(16'h0400, 8'h0B, 1'b1);
    flush();
    idle();
    checks += 3;
    if (Error !== 1'b0) begin errors++; $display("FAIL to_clear got=%b want=0", Error); end
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL to_done2 got=%0d want=%0d", done_cnt, d0 + 1); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL to_writes left=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int d0;
    tx_q = '{8'hA5, 8'h00, 8'h05, 8'h04, 8'h00, 8'h44};
    flush();
    #1;
    checks++;
    if (WE !== 1'b1) begin errors++; $display("FAIL mid_we_live got=%b want=1", WE); end
    RESET_N = 1'b0;
    #1;
    checks += 6;
    if (WE !== 1'b0) begin errors++; $display("FAIL mid_we got=%b want=0", WE); end
    if (Address !== 16'h0) begin errors++; $display("FAIL mid_addr got=%h want=0", Address); end
    if (DataOut !== 8'h0) begin errors++; $display("FAIL mid_dout got=%h want=0", DataOut); end
    if (CpuHold !== 1'b1) begin errors++; $display("FAIL mid_hold got=%b want=1", CpuHold); end
    if (InReady !== 1'b1) begin errors++; $display("FAIL mid_rdy got=%b want=1", InReady); end
    if (Error !== 1'b0) begin errors++; $display("FAIL mid_err got=%b want=0", Error); end
    InValid = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    d0 = done_cnt;
    dq = '{8'h77};
    build(16'h0600, 8'h77, 1'b1);
    flush();
    idle();
    checks += 3;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mid_writes left=%0d want=0", exp_q.size()); end
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL mid_done got=%0d want=%0d", done_cnt, d0 + 1); end
    if (CpuHold !== 1'b0) begin errors++; $display("FAIL mid_hold2 got=%b want=0", CpuHold); end
  endtask

  initial begin
    test_reset();
    test_bad_csum();
    test_basic();
    test_wrap();
    test_garbage();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
